// File: rtl/conv_layer_sequencer.sv
// Buffers one input frame, starts a bank of conv units, replays the frame to them in lockstep,
// then gathers every unit's result into one layer word offered downstream via valid/yumi.
module conv_layer_sequencer #(
    parameter int NUM_CONV           = 4,
    parameter int INPUT_LAYER_HEIGHT = 4,
    parameter int KERNEL_WIDTH       = 2,
    parameter int OUT_HEIGHT         = 2,
    parameter int WORD_SIZE          = 16
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic                                   valid_i,
    output logic                                   ready_o,
    input  logic [WORD_SIZE-1:0]                   data_i,
    output logic                                   conv_start_o,
    output logic [NUM_CONV-1:0]                    conv_valid_o,
    input  logic [NUM_CONV-1:0]                    conv_ready_i,
    output logic [WORD_SIZE-1:0]                   conv_data_o,
    input  logic [NUM_CONV-1:0]                    conv_done_i,
    output logic [NUM_CONV-1:0]                    conv_yumi_o,
    input  logic [NUM_CONV*OUT_HEIGHT*WORD_SIZE-1:0] conv_data_i,
    output logic                                   valid_o,
    input  logic                                   yumi_i,
    output logic [NUM_CONV*OUT_HEIGHT*WORD_SIZE-1:0] data_o
);

    localparam int FRAME_LEN = INPUT_LAYER_HEIGHT * KERNEL_WIDTH;
    localparam int IDX_W     = $clog2(FRAME_LEN + 1);
    localparam int ADDR_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int LANE_W    = OUT_HEIGHT * WORD_SIZE;

    typedef enum logic [2:0] {eLOAD, eSTART, eFEED, eWAIT, eOUT} state_t;

    state_t                          r_state;
    logic [IDX_W-1:0]                r_idx;
    logic [WORD_SIZE-1:0]            r_buf [FRAME_LEN];
    logic [NUM_CONV-1:0]             r_mask;
    logic [NUM_CONV*LANE_W-1:0]      r_data;
    logic                            r_ready;
    logic                            r_start;
    logic                            r_valid;

    logic                            w_all_rdy;
    logic                            w_last;
    logic [NUM_CONV-1:0]             w_yumi;
    logic [NUM_CONV-1:0]             w_mask_nxt;

    assign w_all_rdy  = &conv_ready_i;
    assign w_last     = (r_idx == IDX_W'(FRAME_LEN - 1));
    // Only lanes not yet captured are consumed; repeated done from a finished lane is ignored.
    assign w_yumi     = (r_state == eWAIT) ? (conv_done_i & ~r_mask) : '0;
    assign w_mask_nxt = r_mask | w_yumi;

    assign ready_o      = r_ready;
    assign conv_start_o = r_start;
    assign valid_o      = r_valid;
    assign data_o       = r_data;
    assign conv_yumi_o  = w_yumi;
    assign conv_valid_o = {NUM_CONV{(r_state == eFEED) && w_all_rdy}};
    assign conv_data_o  = r_buf[r_idx[ADDR_W-1:0]];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= eLOAD;
            r_idx   <= '0;
            r_mask  <= '0;
            r_data  <= '0;
            r_ready <= 1'b1;
            r_start <= 1'b0;
            r_valid <= 1'b0;
            for (int i = 0; i < FRAME_LEN; i++) r_buf[i] <= '0;
        end else begin
            case (r_state)
                eLOAD: begin
                    if (valid_i && r_ready) begin
                        r_buf[r_idx[ADDR_W-1:0]] <= data_i;
                        if (w_last) begin
                            r_idx   <= '0;
                            r_ready <= 1'b0;
                            r_start <= 1'b1;
                            r_state <= eSTART;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                eSTART: begin
                    r_start <= 1'b0;
                    r_state <= eFEED;
                end
                // A single lagging unit stalls the whole bank so every unit sees identical words.
                eFEED: begin
                    if (w_all_rdy) begin
                        if (w_last) begin
                            r_idx   <= '0;
                            r_state <= eWAIT;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                eWAIT: begin
                    for (int k = 0; k < NUM_CONV; k++) begin
                        if (w_yumi[k]) r_data[k*LANE_W +: LANE_W] <= conv_data_i[k*LANE_W +: LANE_W];
                    end
                    r_mask <= w_mask_nxt;
                    if (&w_mask_nxt) begin
                        r_valid <= 1'b1;
                        r_state <= eOUT;
                    end
                end
                eOUT: begin
                    if (yumi_i) begin
                        r_mask  <= '0;
                        r_idx   <= '0;
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= eLOAD;
                    end
                end
                default: begin
                    r_state <= eLOAD;
                    r_ready <= 1'b1;
                    r_start <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Randomized bench for conv_layer_sequencer with a two-unit bank and 8-word frames.
module tb_conv_layer_sequencer;

    localparam int NC = 2;
    localparam int FL = 8;

    logic          clk_i = 1'b0;
    logic          reset_n_i;
    logic          valid_i;
    logic          ready_o;
    logic [15:0]   data_i;
    logic          conv_start_o;
    logic [NC-1:0] conv_valid_o;
    logic [NC-1:0] conv_ready_i;
    logic [15:0]   conv_data_o;
    logic [NC-1:0] conv_done_i;
    logic [NC-1:0] conv_yumi_o;
    logic [63:0]   conv_data_i;
    logic          valid_o;
    logic          yumi_i;
    logic [63:0]   data_o;

    conv_layer_sequencer #(
        .NUM_CONV(NC), .INPUT_LAYER_HEIGHT(4), .KERNEL_WIDTH(2), .OUT_HEIGHT(2), .WORD_SIZE(16)
    ) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
        .conv_start_o(conv_start_o), .conv_valid_o(conv_valid_o), .conv_ready_i(conv_ready_i),
        .conv_data_o(conv_data_o), .conv_done_i(conv_done_i), .conv_yumi_o(conv_yumi_o),
        .conv_data_i(conv_data_i), .valid_o(valid_o), .yumi_i(yumi_i), .data_o(data_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] frame [FL];
    logic [63:0] exp_out;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Offers a fresh random frame with random upstream gaps, then checks the start pulse.
    task automatic load_frame(input int gap_pct);
        int i = 0;
        int cyc = 0;
        for (int n = 0; n < FL; n++) frame[n] = 16'($urandom);
        while (i < FL) begin
            @(negedge clk_i);
            valid_i = ($urandom_range(99) >= gap_pct);
            data_i  = valid_i ? frame[i] : 16'($urandom);
            yumi_i  = 1'($urandom_range(1));
            #1;
            chk("ld_ready", ready_o, 1);
            chk("ld_valid_o", valid_o, 0);
            if (valid_i) i++;
            if (++cyc > 200) begin chk("ld_timeout", 0, 1); break; end
        end
        @(negedge clk_i);
        valid_i = 0;
        yumi_i  = 0;
        #1;
        chk("st_ready", ready_o, 0);
        chk("st_pulse", conv_start_o, 1);
    endtask

    // Streams the frame out; returns early with an async reset once abort_after words went out.
    task automatic feed_frame(input int stall_pct, input bit skew, input int abort_after);
        int j = 0;
        int cyc = 0;
        logic all;
        while (j < FL) begin
            @(negedge clk_i);
            if (skew && cyc >= 2 && cyc <= 4) conv_ready_i = 2'b01;
            else if ($urandom_range(99) < stall_pct) conv_ready_i = 2'($urandom);
            else conv_ready_i = 2'b11;
            #1;
            all = &conv_ready_i;
            chk("fd_valid", conv_valid_o, {NC{all}});
            chk("fd_start", conv_start_o, 0);
            chk("fd_ready", ready_o, 0);
            if (all) begin
                chk("fd_data", conv_data_o, frame[j]);
                j++;
            end
            if (abort_after > 0 && j == abort_after) begin
                #2 reset_n_i = 0;
                #1;
                chk("rst_ready", ready_o, 1);
                chk("rst_cvalid", conv_valid_o, 0);
                chk("rst_valid_o", valid_o, 0);
                chk("rst_data_o", data_o, 0);
                @(negedge clk_i);
                reset_n_i = 1;
                conv_ready_i = 2'b11;
                return;
            end
            if (++cyc > 300) begin chk("fd_timeout", 0, 1); break; end
        end
        conv_ready_i = 2'b11;
    endtask

    // Each lane raises done after its delay; already-captured lanes may keep done high with junk data.
    task automatic collect(input int d0, input int d1, input logic [31:0] r0, input logic [31:0] r1);
        int          dly [NC];
        logic [31:0] res [NC];
        logic [NC-1:0] got = '0;
        logic [NC-1:0] ey;
        int t = 0;
        dly[0] = d0; dly[1] = d1; res[0] = r0; res[1] = r1;
        exp_out = {r1, r0};
        while (got != '1) begin
            @(negedge clk_i);
            for (int k = 0; k < NC; k++) begin
                if (got[k]) begin
                    conv_done_i[k] = 1'($urandom_range(1));
                    conv_data_i[k*32 +: 32] = $urandom;
                end else begin
                    conv_done_i[k] = (t >= dly[k]);
                    conv_data_i[k*32 +: 32] = (t >= dly[k]) ? res[k] : $urandom;
                end
            end
            #1;
            ey = conv_done_i & ~got;
            chk("cl_yumi", conv_yumi_o, ey);
            chk("cl_valid_o", valid_o, 0);
            chk("cl_cvalid", conv_valid_o, 0);
            got |= ey;
            if (++t > 100) begin chk("cl_timeout", 0, 1); break; end
        end
        @(negedge clk_i);
        conv_done_i = '1;
        conv_data_i = {$urandom, $urandom};
        #1;
        chk("out_valid", valid_o, 1);
        chk("out_data", data_o, exp_out);
        chk("out_yumi_idle", conv_yumi_o, 0);
        conv_done_i = '0;
    endtask

    task automatic drain(input int stall);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk_i);
            yumi_i = 0;
            valid_i = 1'($urandom_range(1));
            #1;
            chk("dr_valid", valid_o, 1);
            chk("dr_data", data_o, exp_out);
            chk("dr_ready", ready_o, 0);
        end
        @(negedge clk_i);
        yumi_i = 1;
        valid_i = 0;
        #1;
        chk("dr_take", valid_o, 1);
        @(negedge clk_i);
        yumi_i = 0;
        #1;
        chk("dr_after_valid", valid_o, 0);
        chk("dr_after_ready", ready_o, 1);
    endtask

    initial begin
        reset_n_i    = 0;
        valid_i      = 0;
        data_i       = '0;
        conv_ready_i = 2'b11;
        conv_done_i  = '0;
        conv_data_i  = '0;
        yumi_i       = 0;
        repeat (2) @(negedge clk_i);
        #1;
        chk("rs_ready", ready_o, 1);
        chk("rs_valid_o", valid_o, 0);
        chk("rs_start", conv_start_o, 0);
        chk("rs_cvalid", conv_valid_o, 0);
        chk("rs_yumi", conv_yumi_o, 0);
        chk("rs_data_o", data_o, 0);
        @(negedge clk_i);
        reset_n_i = 1;

        // Staggered completion and a 10-cycle downstream stall.
        load_frame(0);
        feed_frame(0, 0, 0);
        collect(2, 7, 32'h0011_0022, 32'h0033_0044);
        drain(10);

        // Ready skew during feed, then both lanes finishing together.
        load_frame(20);
        feed_frame(0, 1, 0);
        collect(3, 3, $urandom, $urandom);
        drain(0);

        // Reset mid-feed, then a clean frame.
        load_frame(0);
        feed_frame(0, 0, 3);
        load_frame(0);
        feed_frame(0, 0, 0);
        collect(1, 0, $urandom, $urandom);
        drain(2);

        for (int f = 0; f < 25; f++) begin
            load_frame($urandom_range(50));
            feed_frame($urandom_range(60), 0, 0);
            collect($urandom_range(8), $urandom_range(8), $urandom, $urandom);
            drain($urandom_range(5));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
